add_round_key_seq: RTL and testbench

ADD_ROUND_KEY_SEQ -- requirements
Module: add_round_key_seq

---
 rtl/aes_pkg.sv | 13 +
 rtl/add_round_key.sv | 14 +
 rtl/add_round_key_seq.sv | 109 ++++++++++
 tb/tb_add_round_key_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: byte-engine FSM states and default block geometry.
package aes_pkg;

    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/add_round_key.sv
// One-byte AddRoundKey datapath: result byte is state byte XOR key byte.
module add_round_key
    import aes_pkg::*;
#(
    parameter int WIDTH = BYTE_W
) (
    input  logic [WIDTH-1:0] state_byte,
    input  logic [WIDTH-1:0] key_byte,
    output logic [WIDTH-1:0] result_byte
);

    assign result_byte = state_byte ^ key_byte;

endmodule

// File: rtl/add_round_key_seq.sv
// Sequential AddRoundKey: captures a state/key block and XORs one byte per cycle,
// presenting the full result with a valid/ready handshake.
module add_round_key_seq #(
    parameter int WIDTH     = aes_pkg::BYTE_W,
    parameter int NUM_BYTES = aes_pkg::NUM_BYTES
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [WIDTH*NUM_BYTES-1:0]     i_state,
    input  logic [WIDTH*NUM_BYTES-1:0]     i_key,
    input  logic                           i_flush,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [WIDTH*NUM_BYTES-1:0]     o_data,
    output logic                           o_busy,
    output logic [$clog2(NUM_BYTES)-1:0]   o_byte_idx
);

    import aes_pkg::state_t;
    import aes_pkg::IDLE;
    import aes_pkg::BUSY;
    import aes_pkg::DONE;

    localparam int IDX_W = $clog2(NUM_BYTES);

    state_t                       state;
    logic [IDX_W-1:0]             cnt;
    logic [WIDTH*NUM_BYTES-1:0]   state_q;
    logic [WIDTH*NUM_BYTES-1:0]   key_q;
    logic [WIDTH-1:0]             state_byte;
    logic [WIDTH-1:0]             key_byte;
    logic [WIDTH-1:0]             result_byte;

    assign state_byte = state_q[cnt*WIDTH +: WIDTH];
    assign key_byte   = key_q[cnt*WIDTH +: WIDTH];

    add_round_key #(
        .WIDTH(WIDTH)
    ) u_xor (
        .state_byte (state_byte),
        .key_byte   (key_byte),
        .result_byte(result_byte)
    );

    // The counter is cleared whenever BUSY is left, so it doubles as the index output.
    assign o_byte_idx = cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_ready <= 1'b1;
            o_data  <= '0;
            state_q <= '0;
            key_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!i_flush && i_valid) begin
                        state_q <= i_state;
                        key_q   <= i_key;
                        cnt     <= '0;
                        state   <= BUSY;
                        o_ready <= 1'b0;
                        o_busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (i_flush) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        o_busy  <= 1'b0;
                        o_ready <= 1'b1;
                        o_valid <= 1'b0;
                    end else begin
                        o_data[cnt*WIDTH +: WIDTH] <= result_byte;
                        if (cnt == IDX_W'(NUM_BYTES - 1)) begin
                            state   <= DONE;
                            cnt     <= '0;
                            o_busy  <= 1'b0;
                            o_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (i_flush || i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_round_key_seq.sv
// Scoreboard bench for add_round_key_seq: the driver queues expected blocks at accept,
// an independent monitor checks every result handshake, latency and the FSM outputs.
module tb_add_round_key_seq;

    localparam int NB  = 16;
    localparam int W   = 8 * NB;
    localparam int LAT = 16;

    logic           clk = 1'b0;
    logic           i_rst;
    logic           i_valid;
    logic           o_ready;
    logic [W-1:0]   i_state;
    logic [W-1:0]   i_key;
    logic           i_flush;
    logic           o_valid;
    logic           i_ready;
    logic [W-1:0]   o_data;
    logic           o_busy;
    logic [3:0]     o_byte_idx;

    typedef struct {
        logic [W-1:0] d;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           last_accept = -1000;
    int           checks = 0;
    int           errors = 0;

    add_round_key_seq #(
        .WIDTH    (8),
        .NUM_BYTES(NB)
    ) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_state   (i_state),
        .i_key     (i_key),
        .i_flush   (i_flush),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_busy    (o_busy),
        .o_byte_idx(o_byte_idx)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got time limit exp completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_block();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Monitor: checks index sequence, ready/valid exclusivity, latency, stability and data.
    initial begin
        logic         prev_valid = 1'b0;
        logic [W-1:0] prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!i_rst) begin
                if (o_busy) chk("byte_idx", W'(o_byte_idx), W'((cyc - last_accept) % NB));
                else        chk("idx_zero", W'(o_byte_idx), '0);
                chk("ready_idle_only", W'(o_ready), W'(!(o_busy || o_valid)));
                if (o_valid && !prev_valid) begin
                    if (sb.size() == 0) chk("unexpected_valid", W'(o_valid), '0);
                    else                chk("latency", W'(cyc - sb[0].acc), W'(LAT));
                end
                if (o_valid && prev_valid) chk("hold_data", o_data, prev_data);
                if (o_valid && i_ready && !i_flush && sb.size() > 0) begin
                    chk("result", o_data, sb[0].d);
                    void'(sb.pop_front());
                end
            end
            prev_valid = o_valid;
            prev_data  = o_data;
        end
    end

    task automatic send(input logic [W-1:0] s, input logic [W-1:0] k, input bit expect_out);
        bit got = 0;
        exp_t e;
        i_state = s;
        i_key   = k;
        i_valid = 1'b1;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (o_ready && !i_flush && !i_rst) begin
                got = 1;
                last_accept = cyc + 1;
                if (expect_out) begin
                    e.d   = s ^ k;
                    e.acc = cyc + 1;
                    sb.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        if (!got) chk("accept_timeout", '0, W'(1));
        i_valid = 1'b0;
    endtask

    task automatic wait_done(input bit rnd_ready);
        for (int n = 0; n < 300 && sb.size() > 0; n++) begin
            @(posedge clk);
            #1;
            if (rnd_ready) i_ready = 1'($urandom_range(0, 1));
        end
        if (sb.size() > 0) chk("done_timeout", W'(sb.size()), '0);
        i_ready = 1'b1;
    endtask

    task automatic wait_idx(input int idx);
        bit hit = 0;
        for (int n = 0; n < 40 && !hit; n++) begin
            @(negedge clk);
            if (o_busy && o_byte_idx == 4'(idx)) hit = 1;
        end
        if (!hit) chk("idx_timeout", '0, W'(1));
    endtask

    initial begin
        logic [W-1:0] a;
        int c0;
        i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        i_state = '0; i_key = '0;
        repeat (2) @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", W'(o_ready), W'(1));
        chk("rst_valid", W'(o_valid), '0);
        chk("rst_busy",  W'(o_busy), '0);
        chk("rst_data",  o_data, '0);
        @(posedge clk); #1;

        // FIPS-197 round 0 vector with an explicit result check
        send(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 1);
        wait_done(0);
        chk("fips_data", o_data, 128'h00102030405060708090a0b0c0d0e0f0);

        // Backpressure in DONE with a competing offer on i_valid
        i_ready = 1'b0;
        send(rnd_block(), rnd_block(), 1);
        begin
            bit seen = 0;
            for (int n = 0; n < 40 && !seen; n++) begin
                @(negedge clk);
                if (o_valid) seen = 1;
            end
            if (!seen) chk("bp_valid_timeout", '0, W'(1));
        end
        @(posedge clk); #1;
        a = rnd_block();
        i_state = a; i_key = '1; i_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_valid_held", W'(o_valid), W'(1));
            chk("bp_ready_low",  W'(o_ready), '0);
            @(posedge clk); #1;
        end
        c0 = cyc;
        i_ready = 1'b1;
        send(a, '1, 1);
        chk("bp_accept_after_hs", W'(last_accept), W'(c0 + 2));
        wait_done(0);

        // Back-to-back blocks
        send('1, '0, 1);
        send('1, '1, 1);
        wait_done(0);
        chk("b2b_last", o_data, '0);

        // Operand change mid-block
        send(rnd_block(), rnd_block(), 1);
        for (int n = 0; n < 10; n++) begin
            i_state = rnd_block();
            i_key   = rnd_block();
            @(posedge clk); #1;
        end
        wait_done(0);

        // Flush at byte 7, then a normal block
        send(rnd_block(), rnd_block(), 0);
        wait_idx(7);
        i_flush = 1'b1;
        @(posedge clk); #1 i_flush = 1'b0;
        @(negedge clk);
        chk("flush_busy",  W'(o_busy), '0);
        chk("flush_valid", W'(o_valid), '0);
        chk("flush_ready", W'(o_ready), W'(1));
        repeat (20) @(posedge clk);
        #1;
        send(rnd_block(), rnd_block(), 1);
        wait_done(0);

        // Async reset mid-block at byte 10
        send(rnd_block(), rnd_block(), 0);
        wait_idx(10);
        #2 i_rst = 1'b1;
        #1;
        chk("arst_valid", W'(o_valid), '0);
        chk("arst_busy",  W'(o_busy), '0);
        chk("arst_data",  o_data, '0);
        @(posedge clk); #1 i_rst = 1'b0;
        @(negedge clk);
        chk("arst_ready", W'(o_ready), W'(1));
        repeat (20) @(posedge clk);
        #1;

        // Randomized blocks with random downstream backpressure
        for (int b = 0; b < 12; b++) begin
            i_ready = 1'b0;
            send(rnd_block(), rnd_block(), 1);
            wait_done(1);
        end

        repeat (3) @(posedge clk);
        chk("sb_empty", W'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
